// File: rtl/poly_coeff_collector.sv
// ---------------------------------------------------------------------------
// poly_coeff_collector
//
// Gathers the accepted samples of a multi-lane rejection sampler into one
// polynomial of N_COEFF coefficients and streams them out one per cycle.
// Accepted lanes of each input beat are compacted (lowest lane first) into a
// small circular buffer; the buffer drains through an AXI-Stream-style port
// that also carries the coefficient index and a last marker.
//
// Optional build macro: COLLECTOR_STATS_EN
//   defined   -> stat_beats / stat_discard are saturating 16-bit counters
//   undefined -> both ports are tied to zero and no counters exist
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        one-cycle request to collect one polynomial (IDLE only)
//   in_valid     sampler beat valid
//   in_acc       per-lane accept mask
//   in_data      packed lane samples, lane i at [i*CAND_BITS +: CAND_BITS]
//   in_ready     beat accepted when in_valid && in_ready
//   out_tdata    coefficient
//   out_tvalid   coefficient valid
//   out_tready   downstream ready
//   out_tlast    marks coefficient N_COEFF-1
//   out_index    index of the coefficient on out_tdata
//   busy         collector not idle
//   done         one-cycle pulse after the last coefficient has left
//   stat_beats   accepted input beats (stats build only)
//   stat_discard lanes dropped because the polynomial was full (stats build)
// ---------------------------------------------------------------------------
module poly_coeff_collector #(
  parameter int LANES     = 4,
  parameter int CAND_BITS = 12,
  parameter int N_COEFF   = 256,
  parameter int BUF_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [LANES-1:0]             in_acc,
  input  logic [LANES*CAND_BITS-1:0]   in_data,
  output logic                         in_ready,
  output logic [CAND_BITS-1:0]         out_tdata,
  output logic                         out_tvalid,
  input  logic                         out_tready,
  output logic                         out_tlast,
  output logic [$clog2(N_COEFF)-1:0]   out_index,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  stat_beats,
  output logic [15:0]                  stat_discard
);

  localparam int PW = $clog2(BUF_DEPTH);    // buffer pointer width
  localparam int CW = PW + 1;               // fill level 0..BUF_DEPTH
  localparam int IW = $clog2(N_COEFF);      // coefficient index width
  localparam int WW = $clog2(N_COEFF + 1);  // write count 0..N_COEFF
  localparam int LW = $clog2(LANES + 1);    // lane count 0..LANES

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state;

  logic [CAND_BITS-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        fill;
  logic [WW-1:0]        wr_cnt;
  logic [IW-1:0]        rd_idx;

  logic [CW-1:0]        free_cnt;
  logic                 beat_acc;
  logic                 pop;
  logic [LW-1:0]        lane_pos [LANES];
  logic [LW-1:0]        acc_pop;
  logic [WW-1:0]        remain;
  logic [LW-1:0]        n_wr;

  // Handshake and output decode; everything here depends only on registered
  // state, so there is no combinational path from the input port to the
  // output port.
  assign free_cnt   = CW'(BUF_DEPTH) - fill;
  assign in_ready   = (state == COLLECT) && (free_cnt >= CW'(LANES));
  assign out_tvalid = (fill != '0) && ((state == COLLECT) || (state == DRAIN));
  // Forced to zero while invalid so the idle/reset value is clean even though
  // the buffer storage itself is never reset.
  assign out_tdata  = out_tvalid ? mem[rd_ptr] : '0;
  assign out_index  = rd_idx;
  assign out_tlast  = out_tvalid && (rd_idx == IW'(N_COEFF - 1));
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  assign beat_acc   = in_valid && in_ready;
  assign pop        = out_tvalid && out_tready;

  // Lane compaction: each accepted lane's slot offset is the number of
  // accepted lanes below it. Only the first n_wr accepted lanes are stored,
  // which drops the highest lanes once the polynomial is nearly full.
  always_comb begin
    acc_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_pos[i] = acc_pop;
      acc_pop     = acc_pop + LW'(in_acc[i]);
    end
    remain = WW'(N_COEFF) - wr_cnt;
    n_wr   = '0;
    if (beat_acc) begin
      if (WW'(acc_pop) > remain) begin
        n_wr = LW'(remain);
      end else begin
        n_wr = acc_pop;
      end
    end
  end

  // Buffer storage: data only, no reset. in_ready guarantees at least LANES
  // free entries, so no slot being written can be the one at rd_ptr that is
  // currently presented; pointer arithmetic wraps since BUF_DEPTH is 2^PW.
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_acc[i] && (lane_pos[i] < n_wr)) begin
          mem[wr_ptr + PW'(lane_pos[i])] <= in_data[i*CAND_BITS +: CAND_BITS];
        end
      end
    end
  end

  // Control FSM and buffer bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      wr_cnt <= '0;
      rd_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= COLLECT;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            wr_cnt <= '0;
            rd_idx <= '0;
          end
        end

        COLLECT: begin
          wr_ptr <= wr_ptr + PW'(n_wr);
          wr_cnt <= wr_cnt + WW'(n_wr);
          fill   <= fill + CW'(n_wr) - CW'(pop);
          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_idx <= rd_idx + 1'b1;
          end
          // The last coefficient is written here; it can only be popped
          // later, so the tlast pop always happens in DRAIN.
          if ((wr_cnt + WW'(n_wr)) == WW'(N_COEFF)) begin
            state <= DRAIN;
          end
        end

        DRAIN: begin
          fill <= fill - CW'(pop);
          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_idx <= rd_idx + 1'b1;
          end
          if (pop && out_tlast) begin
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef COLLECTOR_STATS_EN
  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [15:0]   beats_q;
  logic [15:0]   discard_q;
  logic [LW-1:0] n_drop;

  // Lanes accepted by the sampler but not stored because the polynomial
  // was already (nearly) full.
  assign n_drop = acc_pop - n_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q   <= '0;
      discard_q <= '0;
    end else if ((state == IDLE) && start) begin
      beats_q   <= '0;
      discard_q <= '0;
    end else if (beat_acc) begin
      beats_q   <= sat_add16(beats_q, 16'd1);
      discard_q <= sat_add16(discard_q, 16'(n_drop));
    end
  end

  assign stat_beats   = beats_q;
  assign stat_discard = discard_q;
`else
  assign stat_beats   = 16'd0;
  assign stat_discard = 16'd0;
`endif

endmodule

// File: tb/tb_poly_coeff_collector.sv
// ---------------------------------------------------------------------------
// Directed bench for poly_coeff_collector (default parameters).
// A small scoreboard records the coefficients that should be stored for each
// accepted beat and compares every popped coefficient, index and tlast.
// Directed checks cover reset, compaction, backpressure, the capped final
// beat, a start pulse ignored mid-polynomial and a reset mid-stream.
// ---------------------------------------------------------------------------
module tb_poly_coeff_collector;

  localparam int LANES = 4;
  localparam int CB    = 12;
  localparam int NC    = 256;

`ifdef COLLECTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [LANES-1:0]  in_acc;
  logic [LANES*CB-1:0] in_data;
  logic              in_ready;
  logic [CB-1:0]     out_tdata;
  logic              out_tvalid;
  logic              out_tready;
  logic              out_tlast;
  logic [7:0]        out_index;
  logic              busy;
  logic              done;
  logic [15:0]       stat_beats;
  logic [15:0]       stat_discard;

  poly_coeff_collector #(
    .LANES(LANES), .CAND_BITS(CB), .N_COEFF(NC), .BUF_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_acc(in_acc), .in_data(in_data), .in_ready(in_ready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tlast(out_tlast), .out_index(out_index), .busy(busy), .done(done),
    .stat_beats(stat_beats), .stat_discard(stat_discard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard / model state
  int            m_wr, m_rd, m_beats, m_disc, done_cnt, tl_cnt;
  logic [CB-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    m_wr = 0; m_rd = 0; m_beats = 0; m_disc = 0; done_cnt = 0; tl_cnt = 0;
    exp_q.delete();
  endtask

  task automatic set_beat(input int b, input logic [CB-1:0] xr);
    for (int l = 0; l < LANES; l++)
      in_data[l*CB +: CB] = CB'(b*4 + l) ^ xr;
  endtask

  // One clock: observe handshakes at the falling edge, then let the rising
  // edge happen and return 1 time unit after it.
  task automatic tick();
    logic [CB-1:0] e;
    @(negedge clk);
    if (!rst) begin
      if (in_valid && in_ready) begin
        m_beats++;
        for (int l = 0; l < LANES; l++) begin
          if (in_acc[l]) begin
            if (m_wr < NC) begin
              exp_q.push_back(in_data[l*CB +: CB]);
              m_wr++;
            end else begin
              m_disc++;
            end
          end
        end
      end
      if (out_tvalid && out_tready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pop_data", 32'(out_tdata), 32'(e));
        end
        check("pop_index", 32'(out_index), 32'(m_rd[7:0]));
        check("pop_tlast", 32'(out_tlast), 32'(m_rd == NC - 1));
        if (out_tlast) tl_cnt++;
        m_rd++;
      end
      if (done) done_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string p);
    check({p, "_in_ready"},  32'(in_ready),     32'd0);
    check({p, "_tvalid"},    32'(out_tvalid),   32'd0);
    check({p, "_tlast"},     32'(out_tlast),    32'd0);
    check({p, "_tdata"},     32'(out_tdata),    32'd0);
    check({p, "_index"},     32'(out_index),    32'd0);
    check({p, "_busy"},      32'(busy),         32'd0);
    check({p, "_done"},      32'(done),         32'd0);
    check({p, "_beats"},     32'(stat_beats),   32'd0);
    check({p, "_discard"},   32'(stat_discard), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_acc = '0; in_data = '0;
    out_tready = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;
    tick();

    // ---- full polynomial, all lanes, no backpressure, stray start -----
    clear_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("p1_busy", 32'(busy), 32'd1);
    out_tready = 1'b1;
    in_acc     = 4'b1111;
    for (int c = 0; c < 600 && done_cnt == 0; c++) begin
      in_valid = (m_wr < NC);
      set_beat(m_beats, 12'h000);
      start = (c == 20);
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check("p1_done_seen", 32'(done_cnt), 32'd1);
    check("p1_pops",      32'(m_rd),     32'd256);
    check("p1_tlast_cnt", 32'(tl_cnt),   32'd1);
    check("p1_beats",     32'(m_beats),  32'd64);
    tick();
    tick();
    check("p1_done_once", 32'(done_cnt), 32'd1);
    check("p1_idle_busy", 32'(busy),     32'd0);
    check("p1_idle_rdy",  32'(in_ready), 32'd0);

    // ---- compaction of a sparse beat ----------------------------------
    clear_model();
    out_tready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("p2_stat_clr", 32'(stat_beats), 32'd0);
    in_valid = 1'b1;
    in_acc   = 4'b1010;
    in_data  = {12'h003, 12'h002, 12'h001, 12'h000};
    tick();
    in_valid = 1'b0;
    #1;
    check("cmp_tvalid", 32'(out_tvalid), 32'd1);
    check("cmp_first",  32'(out_tdata),  32'h001);
    check("cmp_idx0",   32'(out_index),  32'd0);
    out_tready = 1'b1;
    tick();
    out_tready = 1'b0;
    #1;
    check("cmp_second", 32'(out_tdata),  32'h003);
    check("cmp_idx1",   32'(out_index),  32'd1);
    tick();
    check("stall_hold", 32'(out_tdata),  32'h003);
    check("stall_vld",  32'(out_tvalid), 32'd1);
    out_tready = 1'b1;
    tick();
    check("cmp_empty",  32'(out_tvalid), 32'd0);

    // ---- backpressure: buffer fills, in_ready drops -------------------
    out_tready = 1'b0;
    in_valid   = 1'b1;
    in_acc     = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      set_beat(m_beats, 12'h5A5);
      tick();
    end
    check("bp_rdy_12", 32'(in_ready), 32'd1);
    set_beat(m_beats, 12'h5A5);
    tick();
    check("bp_rdy_16", 32'(in_ready),   32'd0);
    check("bp_vld_16", 32'(out_tvalid), 32'd1);
    set_beat(m_beats, 12'h5A5);
    tick();
    check("bp_hold_rdy", 32'(in_ready), 32'd0);
    check("bp_no_accept", 32'(m_wr),    32'd18);

    // ---- release and fill to 254, then an over-full beat --------------
    out_tready = 1'b1;
    for (int c = 0; c < 400 && m_wr < 254; c++) begin
      in_valid = (m_wr < 254);
      set_beat(m_beats, 12'h5A5);
      tick();
    end
    in_valid = 1'b0;
    check("cap_pre_wr", 32'(m_wr), 32'd254);
    in_valid = 1'b1;
    set_beat(m_beats, 12'h5A5);
    for (int c = 0; c < 20 && m_wr == 254; c++) tick();
    in_valid = 1'b0;
    check("cap_wr",      32'(m_wr),         32'd256);
    check("cap_disc",    32'(m_disc),       32'd2);
    check("cap_busy",    32'(busy),         32'd1);
    check("cap_rdy",     32'(in_ready),     32'd0);
    check("cap_stat_d",  32'(stat_discard), STATS ? 32'd2 : 32'd0);
    check("cap_stat_b",  32'(stat_beats),   STATS ? 32'd65 : 32'd0);
    for (int c = 0; c < 100 && done_cnt == 0; c++) tick();
    check("p2_done",  32'(done_cnt),     32'd1);
    check("p2_pops",  32'(m_rd),         32'd256);
    check("p2_sb",    32'(exp_q.size()), 32'd0);

    // ---- reset in the middle of a polynomial --------------------------
    clear_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_acc = 4'b1111;
    for (int c = 0; c < 400 && m_rd < 100; c++) begin
      in_valid = (m_wr < NC);
      set_beat(m_beats, 12'h0F0);
      tick();
    end
    check("mid_index", 32'(out_index), 32'd100);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk_idle("midrst");
    rst = 1'b0;
    clear_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    set_beat(0, 12'h0F0);
    tick();
    in_valid = 1'b0;
    #1;
    check("rst_new_vld",  32'(out_tvalid), 32'd1);
    check("rst_new_idx",  32'(out_index),  32'd0);
    check("rst_new_data", 32'(out_tdata),  32'h0F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
